// File: rtl/score_display.sv
// score_display
//   Drives a two-digit multiplexed 7-segment score readout from the BCD
//   outputs of score_counter. The tens and ones digits take turns on the
//   display. A copy of both BCD inputs is taken once per frame, so the two
//   digits shown in a frame always belong to the same score. The leading
//   zero is blanked. In OVER the display blinks. In WIN the decimal points
//   are lit.
//
// Ports
//   clk       in   1        system clock
//   nRst_i    in   1        synchronous reset, active-low
//   state     in   state_t  game state (IDLE, RUN, WIN, OVER)
//   bcd_tens  in   4        tens digit from score_counter
//   bcd_ones  in   4        ones digit from score_counter
//   seg       out  7        segments {g,f,e,d,c,b,a}, active-high, registered
//   dp        out  1        decimal point, active-high, registered
//   digit_en  out  2        digit enables, [1]=tens, [0]=ones, registered
//
// Parameters
//   REFRESH_DIV  clk cycles per digit slot (min 2)
//   BLINK_DIV    clk cycles per blink half-period in OVER (min 2)
//
// FSM (digit_sel)
//   state | meaning
//   ONES  | ones slot is being prepared; the snapshot is taken on leaving it
//   TENS  | tens slot is being prepared

package score_display_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        WIN  = 2'd2,
        OVER = 2'd3
    } state_t;
endpackage

module score_display
    import score_display_pkg::*;
#(
    parameter int REFRESH_DIV = 12000,
    parameter int BLINK_DIV   = 6000000
) (
    input  logic       clk,
    input  logic       nRst_i,
    input  state_t     state,
    input  logic [3:0] bcd_tens,
    input  logic [3:0] bcd_ones,
    output logic [6:0] seg,
    output logic       dp,
    output logic [1:0] digit_en
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(BLINK_DIV);

    typedef enum logic {
        ONES = 1'b0,
        TENS = 1'b1
    } digit_sel_t;

    digit_sel_t    digit_sel, digit_sel_nxt;
    logic [RW-1:0] ref_cnt, ref_cnt_nxt;
    logic [3:0]    shadow_tens, shadow_tens_nxt;
    logic [3:0]    shadow_ones, shadow_ones_nxt;
    logic [BW-1:0] blink_cnt, blink_cnt_nxt;
    logic          blink_phase, blink_phase_nxt;
    logic [6:0]    seg_nxt;
    logic          dp_nxt;
    logic [1:0]    digit_en_nxt;
    logic          tick;
    logic          is_win;
    logic          is_over;
    logic [3:0]    shown;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;   // non-BCD input shows a dash
        endcase
        return s;
    endfunction

    always_ff @(posedge clk) begin
        if (!nRst_i) begin
            digit_sel   <= ONES;
            ref_cnt     <= '0;
            shadow_tens <= 4'd0;
            shadow_ones <= 4'd0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            seg         <= 7'h00;
            dp          <= 1'b0;
            digit_en    <= 2'b00;
        end else begin
            digit_sel   <= digit_sel_nxt;
            ref_cnt     <= ref_cnt_nxt;
            shadow_tens <= shadow_tens_nxt;
            shadow_ones <= shadow_ones_nxt;
            blink_cnt   <= blink_cnt_nxt;
            blink_phase <= blink_phase_nxt;
            seg         <= seg_nxt;
            dp          <= dp_nxt;
            digit_en    <= digit_en_nxt;
        end
    end

    always_comb begin
        digit_sel_nxt   = digit_sel;
        ref_cnt_nxt     = ref_cnt + 1'b1;
        shadow_tens_nxt = shadow_tens;
        shadow_ones_nxt = shadow_ones;
        blink_cnt_nxt   = '0;
        blink_phase_nxt = 1'b0;

        // Any encoding that is not WIN or OVER falls through to IDLE behaviour.
        is_win  = (state == WIN);
        is_over = (state == OVER);

        tick = (ref_cnt == RW'(REFRESH_DIV - 1));
        if (tick) begin
            ref_cnt_nxt = '0;
            case (digit_sel)
                ONES: begin
                    // Leaving the ones slot starts a new frame: grab both digits now.
                    digit_sel_nxt   = TENS;
                    shadow_tens_nxt = bcd_tens;
                    shadow_ones_nxt = bcd_ones;
                end
                default: digit_sel_nxt = ONES;
            endcase
        end

        // The blink timer is held cleared outside OVER so that OVER always starts visible.
        if (is_over) begin
            if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                blink_cnt_nxt   = '0;
                blink_phase_nxt = ~blink_phase;
            end else begin
                blink_cnt_nxt   = blink_cnt + 1'b1;
                blink_phase_nxt = blink_phase;
            end
        end

        shown        = (digit_sel == TENS) ? shadow_tens : shadow_ones;
        seg_nxt      = seg7(shown);
        dp_nxt       = is_win;
        digit_en_nxt = (digit_sel == TENS) ? 2'b10 : 2'b01;

        if (((digit_sel == TENS) && (shadow_tens == 4'd0)) || (is_over && blink_phase)) begin
            seg_nxt      = 7'h00;
            dp_nxt       = 1'b0;
            digit_en_nxt = 2'b00;
        end
    end

endmodule

// File: tb/tb_score_display.sv
module tb_score_display;
    import score_display_pkg::*;

    localparam int RD = 4;
    localparam int BD = 8;
    localparam logic [6:0] SEG_LUT [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                             7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic       clk = 1'b0;
    logic       nRst_i = 1'b0;
    state_t     state = IDLE;
    logic [3:0] bcd_tens = 4'd0;
    logic [3:0] bcd_ones = 4'd0;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] digit_en;
    wire  [9:0] obs = {seg, dp, digit_en};

    always #5 clk = ~clk;

    score_display #(.REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
        .clk      (clk),
        .nRst_i   (nRst_i),
        .state    (state),
        .bcd_tens (bcd_tens),
        .bcd_ones (bcd_ones),
        .seg      (seg),
        .dp       (dp),
        .digit_en (digit_en)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [9:0] exp_q [$];

    // reference model state
    int         m_cnt = 0;
    bit         m_sel = 1'b0;
    logic [3:0] m_tens = 4'd0;
    logic [3:0] m_ones = 4'd0;
    int         m_bc = 0;
    bit         m_bp = 1'b0;

    task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got {seg,dp,en}=%h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] dec(input logic [3:0] v);
        if (v > 4'd9) return 7'h40;
        return SEG_LUT[v];
    endfunction

    function automatic logic [9:0] pk(input logic [6:0] s, input logic d, input logic [1:0] en);
        return {s, d, en};
    endfunction

    // Expected output for the k-th edge after reset release when inputs are held.
    function automatic logic [9:0] slot_exp(input int k, input logic [6:0] ts, input logic [6:0] os,
                                           input logic d, input bit tens_blank);
        int s;
        s = (k - 1) / RD;
        if (s == 0) return pk(7'h3F, d, 2'b01);
        if (s % 2 == 1) return tens_blank ? 10'h000 : pk(ts, d, 2'b10);
        return pk(os, d, 2'b01);
    endfunction

    // Compute what the DUT must show after the coming edge and push it.
    task automatic model_step();
        logic [9:0] e;
        logic [3:0] v;
        if (!nRst_i) begin
            e = 10'h000;
            m_cnt = 0; m_sel = 1'b0; m_tens = 4'd0; m_ones = 4'd0; m_bc = 0; m_bp = 1'b0;
        end else begin
            v = m_sel ? m_tens : m_ones;
            if ((state == OVER && m_bp) || (m_sel && m_tens == 4'd0)) e = 10'h000;
            else e = {dec(v), (state == WIN), (m_sel ? 2'b10 : 2'b01)};
            if (m_cnt == RD - 1) begin
                m_cnt = 0;
                if (!m_sel) begin m_tens = bcd_tens; m_ones = bcd_ones; end
                m_sel = !m_sel;
            end else m_cnt++;
            if (state != OVER) begin m_bc = 0; m_bp = 1'b0; end
            else if (m_bc == BD - 1) begin m_bc = 0; m_bp = !m_bp; end
            else m_bc++;
        end
        exp_q.push_back(e);
    endtask

    task automatic cycle();
        logic [9:0] e;
        model_step();
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("sb_empty", obs, 10'h3FF);
        end else begin
            e = exp_q.pop_front();
            check("sb", obs, e);
        end
    endtask

    task automatic restart(input state_t st, input logic [3:0] t, input logic [3:0] o);
        nRst_i = 1'b0;
        cycle();
        state = st; bcd_tens = t; bcd_ones = o;
        nRst_i = 1'b1;
    endtask

    initial begin
        logic [9:0] e;

        // 1. reset, release, mid-frame reset
        nRst_i = 1'b0;
        repeat (3) begin
            cycle();
            check("rst_hold", obs, 10'h000);
        end
        nRst_i = 1'b1; state = RUN;
        cycle();
        check("rst_release", obs, pk(7'h3F, 1'b0, 2'b01));
        repeat (5) cycle();
        nRst_i = 1'b0;
        cycle();
        check("rst_mid", obs, 10'h000);

        // 2. RUN 47
        restart(RUN, 4'd4, 4'd7);
        for (int k = 1; k <= 20; k++) begin
            cycle();
            check("run47", obs, slot_exp(k, 7'h66, 7'h07, 1'b0, 1'b0));
        end

        // 3. RUN 05, leading zero blank
        restart(RUN, 4'd0, 4'd5);
        for (int k = 1; k <= 16; k++) begin
            cycle();
            check("blank05", obs, slot_exp(k, 7'h00, 7'h6D, 1'b0, 1'b1));
        end

        // 4. 39 -> 40 one cycle into the tens slot
        restart(RUN, 4'd3, 4'd9);
        for (int k = 1; k <= 20; k++) begin
            cycle();
            if (k <= 4)       e = pk(7'h3F, 1'b0, 2'b01);
            else if (k <= 8)  e = pk(7'h4F, 1'b0, 2'b10);
            else if (k <= 12) e = pk(7'h6F, 1'b0, 2'b01);
            else if (k <= 16) e = pk(7'h66, 1'b0, 2'b10);
            else              e = pk(7'h3F, 1'b0, 2'b01);
            check("tearfree", obs, e);
            if (k == 5) begin bcd_tens = 4'd4; bcd_ones = 4'd0; end
        end

        // 5. OVER blink, leave while dark, re-enter visible
        restart(OVER, 4'd2, 4'd3);
        for (int k = 1; k <= 27; k++) begin
            cycle();
            if (((k - 1) / BD) % 2 == 1) check("blink_dark", obs, 10'h000);
            else check("blink_vis", obs, slot_exp(k, 7'h5B, 7'h4F, 1'b0, 1'b0));
        end
        state = IDLE;
        cycle();
        check("over_exit", obs, pk(7'h4F, 1'b0, 2'b01));
        state = OVER;
        for (int k = 29; k <= 37; k++) begin
            cycle();
            if (k == 37) check("reenter_dark", obs, 10'h000);
            else check("reenter_vis", obs, slot_exp(k, 7'h5B, 7'h4F, 1'b0, 1'b0));
        end

        // 6. WIN, dp lit, non-BCD ones shows dash
        restart(WIN, 4'd1, 4'hA);
        for (int k = 1; k <= 16; k++) begin
            cycle();
            check("win", obs, slot_exp(k, 7'h06, 7'h40, 1'b1, 1'b0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
